// File: rtl/nco_carrier.sv
// Numerically-controlled carrier: phase accumulator + quarter-wave sine LUT, 3-stage pipe.
// Optional quadrature cosine output when QUAD_COS_EN is defined.

module nco_carrier_path #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 6,
  parameter int AMP_W   = 16
) (
  input  logic               clk_sig,
  input  logic               rst_n,
  input  logic [2:0]         stg_en_i,
  input  logic [PHASE_W-1:0] p_i,
  output logic [AMP_W-1:0]   smp_o
);
  localparam int LN = 2**LUT_AW;

  // Elaboration-time Taylor series; the table is folded to constants.
  function automatic logic [AMP_W-2:0] lut_val(input int k);
    real x, t, s;
    x = 1.5707963267948966 * k / real'(LN);
    t = x;
    s = x;
    for (int n = 1; n < 12; n++) begin
      t = -t * x * x / real'((2*n) * (2*n + 1));
      s = s + t;
    end
    return (AMP_W-1)'($rtoi(s * real'(2**(AMP_W-1) - 1) + 0.5));
  endfunction

  logic [AMP_W-2:0] lut [0:LN];
  for (genvar k = 0; k <= LN; k++) begin : g_lut
    localparam logic [AMP_W-2:0] V = lut_val(k);
    assign lut[k] = V;
  end

  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  logic [LUT_AW:0]   addr_d, addr_q;
  logic              sgn1_q, sgn2_q;
  logic [AMP_W-2:0]  mag_q;
  logic [AMP_W-1:0]  smp_q;
  logic              unused_p;

  assign quad     = p_i[PHASE_W-1 -: 2];
  assign idx      = p_i[PHASE_W-3 -: LUT_AW];
  assign unused_p = ^p_i;
  // Odd quadrants mirror the quarter wave; idx 0 there addresses the peak entry.
  assign addr_d   = quad[0] ? ((LUT_AW+1)'(LN) - {1'b0, idx}) : {1'b0, idx};

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      sgn1_q <= 1'b0;
      mag_q  <= '0;
      sgn2_q <= 1'b0;
      smp_q  <= '0;
    end else begin
      if (stg_en_i[0]) begin
        addr_q <= addr_d;
        sgn1_q <= quad[1];
      end
      if (stg_en_i[1]) begin
        mag_q  <= lut[addr_q];
        sgn2_q <= sgn1_q;
      end
      if (stg_en_i[2])
        smp_q <= sgn2_q ? -{1'b0, mag_q} : {1'b0, mag_q};
    end
  end

  assign smp_o = smp_q;
endmodule

module nco_carrier #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 6,
  parameter int AMP_W   = 16
) (
  input  logic               clk_sig,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_ld,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic               bpsk_bit,
  input  logic               sync_clr,
  output logic [AMP_W-1:0]   sin_out,
  output logic               out_valid
`ifdef QUAD_COS_EN
  ,
  output logic [AMP_W-1:0]   cos_out
`endif
);
`ifdef QUAD_COS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic [PHASE_W-1:0] acc_d, acc_q, ftw_d, ftw_q, p;
  logic [3:1]         vld_pipe_q;
  logic [2:0]         stg_en;
  logic [NP-1:0][PHASE_W-1:0] p_lanes;
  logic [NP-1:0][AMP_W-1:0]   smp;

  always_comb begin
    acc_d = acc_q;
    if (sync_clr)  acc_d = '0;
    else if (en)   acc_d = acc_q + ftw_q;
    ftw_d = ftw_ld ? ftw_in : ftw_q;
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ftw_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      acc_q      <= acc_d;
      ftw_q      <= ftw_d;
      vld_pipe_q <= {vld_pipe_q[2:1], en};
    end
  end

  // BPSK flip is a half-turn added to the phase before folding.
  assign p      = acc_q + phase_ofs + {bpsk_bit, {(PHASE_W-1){1'b0}}};
  assign stg_en = {vld_pipe_q[2:1], en};

  assign p_lanes[0] = p;
`ifdef QUAD_COS_EN
  assign p_lanes[1] = p + {2'b01, {(PHASE_W-2){1'b0}}};
  assign cos_out    = smp[1];
`endif

  for (genvar g = 0; g < NP; g++) begin : g_path
    nco_carrier_path #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_path (
      .clk_sig  (clk_sig),
      .rst_n    (rst_n),
      .stg_en_i (stg_en),
      .p_i      (p_lanes[g]),
      .smp_o    (smp[g])
    );
  end

  assign sin_out   = smp[0];
  assign out_valid = vld_pipe_q[3];
endmodule
